// File: rtl/mem_access_unit.sv
// RV32I MEM-stage data access over a req/gnt/rvalid word bus; returns extended load data.
// Latency: error 1, store 2+gnt wait, load 3+gnt/rvalid wait; stall holds the pipe until resp_valid.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic [3:0]    acc_q;
    logic [1:0]    off_q;
    logic          legal;
    logic          misaligned;
    logic          timeout_hit;
    logic [3:0]    st_wmask;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign stall       = req_valid && !req_ready;
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_comb begin
        if (req_we)
            legal = req_access inside {4'b1000, 4'b1001, 4'b1010};
        else
            legal = req_access inside {4'b0100, 4'b0101, 4'b0110, 4'b0000, 4'b0001};
        misaligned = 1'b0;
        st_wdata   = req_wdata;
        st_wmask   = 4'b0000;
        case (req_access[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                misaligned = req_addr[0];
                st_wdata   = {2{req_wdata[15:0]}};
                st_wmask   = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                misaligned = |req_addr[1:0];
                st_wmask   = 4'b1111;
            end
        endcase
        if (!req_we)
            st_wmask = 4'b0000;
    end

    // Lane selection uses the offset/code latched at accept, not the live request.
    always_comb begin
        ld_byte = mem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (acc_q[1:0])
            2'b00:   ld_data = {{24{acc_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{acc_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
            to_cnt     <= '0;
            acc_q      <= '0;
            off_q      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc_q     <= req_access;
                        off_q     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        to_cnt    <= '0;
                        if (!legal || misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ISSUE;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wmask <= st_wmask;
                            mem_wdata <= st_wdata;
                        end
                    end
                end
                ISSUE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else if (timeout_hit) begin
                            // Load granted in its last budgeted cycle: no cycle left for rvalid.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req    <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ld_data;
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access unit in the MEM stage of the pipelined RV32I core. It consumes the decoder's dmem_access and dmem_we encodings together with the ALU-computed address. It performs the access over a word-wide request/grant/rvalid memory bus and returns the sign- or zero-extended load data for rf_wd_sel=2'b10 writeback. It stalls the pipeline until each access completes.

Parameters:
TIMEOUT, 255, max cycles spent in ISSUE+WAIT before aborting with resp_err; 0 disables timeout.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  1  MEM-stage access request
req_ready  output  1  unit can accept a request (state IDLE)
req_we  input  1  1=store, 0=load (decoder dmem_we)
req_access  input  4  decoder dmem_access code
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2 value)
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal code or timeout; valid with resp_valid
stall  output  1  req_valid && !(state==IDLE)
mem_req  output  1  bus request
mem_we  output  1  bus write
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wmask  output  4  byte-lane write enables
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  bus accepted request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Reset values: state IDLE, all outputs 0, except req_ready=1 and mem_addr=0.
- Legal load codes (req_we=0): 0100 LB, 0101 LH, 0110 LW, 0000 LBU, 0001 LHU.
- Legal store codes (req_we=1): 1000 SB, 1001 SH, 1010 SW. Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: on req_valid, latch we/access/addr/wdata. If illegal or misaligned, go to RESP with err=1 and no bus activity. Otherwise go to ISSUE.
  - ISSUE: mem_req=1 with stable mem_we/addr/wmask/wdata until mem_gnt. On a store grant, go to RESP. On a load grant, go to WAIT.
  - WAIT: on mem_rvalid, capture the extracted data and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. resp_rdata and resp_err are held until the next RESP.
- Store lanes:
  - SB: wdata={4{b}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wmask=4'b0011<<{addr[1],1'b0}.
  - SW: wmask=4'b1111.
  - For loads, wmask=0.
- Load extract: byte lane addr[1:0], half lane addr[1]. Sign-extend when access[2]=1 (LB/LH); zero-extend for LBU/LHU.
- Minimum latency (accept cycle = 0):
  - Store with immediate gnt: resp_valid at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2: resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Timeout: a counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle. When it reaches TIMEOUT (and TIMEOUT!=0), drop mem_req, go to RESP with err=1 and rdata=0.
- mem_rvalid is ignored outside WAIT; a late rvalid after a timeout or reset is discarded.
- mem_rvalid in the same cycle as mem_gnt (ISSUE) is ignored; the bus must return rvalid at least one cycle after gnt.
- req_valid is ignored while not IDLE. The upstream holds the request while stall=1.
- rst mid-access: IDLE on the next edge, mem_req deasserted, no resp_valid generated.

Test Plan:
- LW addr 0x100, gnt cycle 1, rvalid cycle 2 with rdata 0xDEADBEEF -> resp_valid cycle 3, rdata 0xDEADBEEF, err 0.
- LB addr 0x103 with rdata 0x80FF0011 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF. LHU -> 0x000080FF.
- SB addr 0x201, wdata 0x000000AB -> mem_wmask 0010, mem_wdata 0xABABABAB, mem_addr 0x200. SH addr 0x202 wdata 0x1234 -> wmask 1100, wdata 0x12341234.
- SW addr 0x102 -> resp_err=1 at cycle 1, mem_req never asserted. Load code 0111 -> same. Store with access 0000 -> same.
- mem_gnt withheld, TIMEOUT=4 -> mem_req high 4 cycles then drops, resp_err=1. A later rvalid is ignored and stall releases.
- rst asserted during WAIT -> next cycle IDLE, req_ready=1, no resp_valid. Back-to-back requests are each accepted only in IDLE and stall is correct throughout.
